// File: rtl/m6809_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m6809_pkg
// Purpose  : Shared definitions for the 6809 core front end: fetch-sequencer
//            state encodings, opcode constants for the register-move group,
//            default timing parameters and opcode-classification helpers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package m6809_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_OP = 3'd0,
        ST_FETCH_PB = 3'd1,
        ST_MV_ARM   = 3'd2,
        ST_WAIT_MV  = 3'd3,
        ST_WAIT_EX  = 3'd4
    } fetch_state_e;

    localparam logic [7:0] OP_PSHS = 8'h34;
    localparam logic [7:0] OP_PULS = 8'h35;
    localparam logic [7:0] OP_PSHU = 8'h36;
    localparam logic [7:0] OP_PULU = 8'h37;
    localparam logic [7:0] OP_EXG  = 8'h1E;
    localparam logic [7:0] OP_TFR  = 8'h1F;
    localparam logic [7:0] OP_NOP  = 8'h12;

    localparam logic [7:0]  WAIT_MAX_DEFAULT = 8'd32;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'hFFFE;

    // Stack push/pull: the mover takes the bus for several cycles.
    function automatic logic is_stack_op(input logic [7:0] op);
        return (op == OP_PSHS) || (op == OP_PULS) || (op == OP_PSHU) || (op == OP_PULU);
    endfunction

    // Any opcode that needs a post-byte handed to the register mover.
    function automatic logic is_regmove(input logic [7:0] op);
        return is_stack_op(op) || (op == OP_EXG) || (op == OP_TFR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/m6809_core_busmux.sv
`default_nettype none
// ============================================================================
// Module   : m6809_core_busmux
// Purpose  : Combinational 3-way priority bus mux: mover > execute > fetch.
//            The fetch/idle source is always a read at the supplied address
//            with zero write data.
// Ports    : mv_*_i     mover bus request and signals
//            ex_*_i     execute-unit bus request and signals
//            fetch_addr_i  address used for fetch or idle cycles
//            addr_o/rw_n_o/dout_o  selected bus
//            sel_o      one-hot source select {mover, exec, fetch}
// Revision : 1.0 - initial release
// ============================================================================
module m6809_core_busmux (
    input  logic        mv_oe_i,
    input  logic [15:0] mv_addr_i,
    input  logic        mv_rw_n_i,
    input  logic [7:0]  mv_dout_i,
    input  logic        ex_oe_i,
    input  logic [15:0] ex_addr_i,
    input  logic        ex_rw_n_i,
    input  logic [7:0]  ex_dout_i,
    input  logic [15:0] fetch_addr_i,
    output logic [15:0] addr_o,
    output logic        rw_n_o,
    output logic [7:0]  dout_o,
    output logic [2:0]  sel_o
);

    always_comb begin
        sel_o  = 3'b001;
        addr_o = fetch_addr_i;
        rw_n_o = 1'b1;
        dout_o = 8'h00;
        if (mv_oe_i) begin
            sel_o  = 3'b100;
            addr_o = mv_addr_i;
            rw_n_o = mv_rw_n_i;
            dout_o = mv_dout_i;
        end else if (ex_oe_i) begin
            sel_o  = 3'b010;
            addr_o = ex_addr_i;
            rw_n_o = ex_rw_n_i;
            dout_o = ex_dout_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/m6809_core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : m6809_core_fetch
// Purpose  : Opcode / post-byte fetch sequencer feeding the register mover
//            (PSHS/PSHU/PULS/PULU/TFR/EXG) and the execute unit. Fetches the
//            opcode at PC, fetches the post-byte for register-move opcodes
//            while pulsing mv_start_o, yields the bus to the mover or the
//            execute unit while they run, and guards both waits with a
//            watchdog that raises a sticky error.
// Ports    : clk, reset_b (async, active-low)
//            halt_i                 hold in opcode fetch, PC frozen
//            din_i                  memory read data
//            addr_o/data_rw_n_o/dout_o  muxed memory bus
//            ir_out_o/pb_out_o/pc_out_o  IR, post-byte, program counter
//            mv_start_o             one-cycle mover start
//            mv_bus_oe_i, mv_addr_i, mv_rw_n_i, mv_dout_i  mover bus
//            mv_pc_i/mv_pc_en_i     PC load from mover (PUL with PC)
//            ex_req_o/ex_ack_i      execute handshake
//            ex_bus_oe_i, ex_addr_i, ex_rw_n_i, ex_dout_i  execute bus
//            wd_err_o               sticky watchdog error
// Revision : 1.0 - initial release
// ============================================================================
module m6809_core_fetch
    import m6809_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [7:0]  WAIT_MAX = WAIT_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        halt_i,
    input  logic [7:0]  din_i,
    output logic [15:0] addr_o,
    output logic        data_rw_n_o,
    output logic [7:0]  dout_o,
    output logic [7:0]  ir_out_o,
    output logic [7:0]  pb_out_o,
    output logic [15:0] pc_out_o,
    output logic        mv_start_o,
    input  logic        mv_bus_oe_i,
    input  logic [15:0] mv_addr_i,
    input  logic        mv_rw_n_i,
    input  logic [7:0]  mv_dout_i,
    input  logic [15:0] mv_pc_i,
    input  logic        mv_pc_en_i,
    output logic        ex_req_o,
    input  logic        ex_ack_i,
    input  logic        ex_bus_oe_i,
    input  logic [15:0] ex_addr_i,
    input  logic        ex_rw_n_i,
    input  logic [7:0]  ex_dout_i,
    output logic        wd_err_o
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [7:0]   ir_q, ir_d;
    logic [7:0]   pb_q, pb_d;
    logic [7:0]   wd_q, wd_d;
    logic         ex_req_q, ex_req_d;
    logic         wd_err_q, wd_err_d;
    logic         wd_expire;

    logic [15:0]  mux_addr;
    logic         mux_rw_n;
    logic [7:0]   mux_dout;
    logic [2:0]   bus_sel;

    // The counter has been in the wait state for WAIT_MAX cycles this cycle.
    assign wd_expire = (wd_q == (WAIT_MAX - 8'd1));

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        pb_d     = pb_q;
        wd_d     = wd_q;
        ex_req_d = ex_req_q;
        wd_err_d = wd_err_q;

        case (state_q)
            ST_FETCH_OP: begin
                if (!halt_i) begin
                    ir_d = din_i;
                    pc_d = pc_q + 16'd1;
                    wd_d = 8'd0;
                    if (is_regmove(din_i)) begin
                        state_d = ST_FETCH_PB;
                    end else begin
                        state_d  = ST_WAIT_EX;
                        ex_req_d = 1'b1;
                    end
                end
            end
            ST_FETCH_PB: begin
                pb_d = din_i;
                pc_d = pc_q + 16'd1;
                // TFR/EXG complete inside the mover in one cycle; no bus handover.
                state_d = is_stack_op(ir_q) ? ST_MV_ARM : ST_FETCH_OP;
            end
            ST_MV_ARM: begin
                // Mover raises bus_oe one cycle after start; an empty register
                // list never raises it at all.
                if (mv_bus_oe_i) begin
                    state_d = ST_WAIT_MV;
                    wd_d    = 8'd0;
                end else begin
                    state_d = ST_FETCH_OP;
                end
            end
            ST_WAIT_MV: begin
                wd_d = wd_q + 8'd1;
                if (!mv_bus_oe_i) begin
                    state_d = ST_FETCH_OP;
                end else if (wd_expire) begin
                    wd_err_d = 1'b1;
                    state_d  = ST_FETCH_OP;
                end
            end
            ST_WAIT_EX: begin
                wd_d = wd_q + 8'd1;
                // Acknowledge takes priority over a coincident watchdog expiry.
                if (ex_ack_i) begin
                    ex_req_d = 1'b0;
                    state_d  = ST_FETCH_OP;
                end else if (wd_expire) begin
                    ex_req_d = 1'b0;
                    wd_err_d = 1'b1;
                    state_d  = ST_FETCH_OP;
                end
            end
            default: begin
                state_d = ST_FETCH_OP;
            end
        endcase

        // PUL with PC in the register list reloads PC from the mover.
        if (mv_pc_en_i) begin
            pc_d = mv_pc_i;
        end
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q  <= ST_FETCH_OP;
            pc_q     <= RESET_PC;
            ir_q     <= OP_NOP;
            pb_q     <= 8'h00;
            wd_q     <= 8'd0;
            ex_req_q <= 1'b0;
            wd_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            pb_q     <= pb_d;
            wd_q     <= wd_d;
            ex_req_q <= ex_req_d;
            wd_err_q <= wd_err_d;
        end
    end

    m6809_core_busmux u_busmux (
        .mv_oe_i      (mv_bus_oe_i),
        .mv_addr_i    (mv_addr_i),
        .mv_rw_n_i    (mv_rw_n_i),
        .mv_dout_i    (mv_dout_i),
        .ex_oe_i      (ex_bus_oe_i),
        .ex_addr_i    (ex_addr_i),
        .ex_rw_n_i    (ex_rw_n_i),
        .ex_dout_i    (ex_dout_i),
        .fetch_addr_i (pc_q),
        .addr_o       (mux_addr),
        .rw_n_o       (mux_rw_n),
        .dout_o       (mux_dout),
        .sel_o        (bus_sel)
    );

    // The bus is combinational, so it is forced to its idle reset values
    // while reset_b is low rather than following pc or the external masters.
    assign addr_o      = reset_b ? mux_addr : 16'h0000;
    assign data_rw_n_o = reset_b ? mux_rw_n : 1'b1;
    assign dout_o      = reset_b ? mux_dout : 8'h00;

    assign ir_out_o   = ir_q;
    assign pb_out_o   = pb_q;
    assign pc_out_o   = pc_q;
    assign mv_start_o = (state_q == ST_FETCH_PB);
    assign ex_req_o   = ex_req_q;
    assign wd_err_o   = wd_err_q;

`ifndef SYNTHESIS
    a_mv_start_in_pb: assert property (@(posedge clk) disable iff (!reset_b)
        mv_start_o |-> (state_q == ST_FETCH_PB));
    a_single_driver: assert property (@(posedge clk) disable iff (!reset_b)
        $onehot(bus_sel));
    a_req_vs_mover: assert property (@(posedge clk) disable iff (!reset_b)
        !(ex_req_q && mv_bus_oe_i));
`endif

endmodule
`default_nettype wire

// File: tb/tb_m6809_core_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_m6809_core_fetch
// Purpose  : Directed self-checking bench for m6809_core_fetch with a byte
//            memory model and a simple register-mover model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_m6809_core_fetch;

    logic        clk = 1'b0;
    logic        reset_b = 1'b0;
    logic        halt;
    logic [7:0]  din;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  dout;
    logic [7:0]  ir;
    logic [7:0]  pb;
    logic [15:0] pc;
    logic        mv_start;
    logic        mv_bus_oe;
    logic [15:0] mv_addr;
    logic        mv_rw_n;
    logic [7:0]  mv_dout;
    logic [15:0] mv_pc;
    logic        mv_pc_en;
    logic        ex_req;
    logic        ex_ack;
    logic        ex_bus_oe;
    logic [15:0] ex_addr;
    logic        ex_rw_n;
    logic [7:0]  ex_dout;
    logic        wd_err;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mem [0:65535];
    logic [7:0] mv_len;
    logic       mv_pc_mode;
    logic [7:0] mv_cnt;

    always #5 clk = ~clk;

    assign din = mem[addr];

    // Mover model: bus_oe high for mv_len cycles starting the cycle after start.
    always @(posedge clk or negedge reset_b) begin
        if (!reset_b)          mv_cnt <= 8'd0;
        else if (mv_start)     mv_cnt <= mv_len;
        else if (mv_cnt != 0)  mv_cnt <= mv_cnt - 8'd1;
    end
    assign mv_bus_oe = (mv_cnt != 8'd0);
    assign mv_addr   = 16'h01F0 + {8'h00, mv_cnt};
    assign mv_rw_n   = 1'b0;
    assign mv_dout   = {4'hA, mv_cnt[3:0]};
    assign mv_pc_en  = mv_pc_mode && (mv_cnt == 8'd1);
    assign mv_pc     = 16'h1234;

    m6809_core_fetch dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .halt_i      (halt),
        .din_i       (din),
        .addr_o      (addr),
        .data_rw_n_o (rw_n),
        .dout_o      (dout),
        .ir_out_o    (ir),
        .pb_out_o    (pb),
        .pc_out_o    (pc),
        .mv_start_o  (mv_start),
        .mv_bus_oe_i (mv_bus_oe),
        .mv_addr_i   (mv_addr),
        .mv_rw_n_i   (mv_rw_n),
        .mv_dout_i   (mv_dout),
        .mv_pc_i     (mv_pc),
        .mv_pc_en_i  (mv_pc_en),
        .ex_req_o    (ex_req),
        .ex_ack_i    (ex_ack),
        .ex_bus_oe_i (ex_bus_oe),
        .ex_addr_i   (ex_addr),
        .ex_rw_n_i   (ex_rw_n),
        .ex_dout_i   (ex_dout),
        .wd_err_o    (wd_err)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        halt = 1'b0; ex_ack = 1'b0; ex_bus_oe = 1'b0; ex_addr = 16'hDEAD; ex_rw_n = 1'b0; ex_dout = 8'h77;
        mv_len = 8'd0; mv_pc_mode = 1'b0;
        reset_b = 1'b0;
        step(); step();
        tests_run++; if ({ir, pb, pc} !== {8'h12, 8'h00, 16'hFFFE}) begin tests_failed++; $display("FAIL reset_regs: got ir/pb/pc %h %h %h exp 12 00 fffe", ir, pb, pc); end
        tests_run++; if ({mv_start, ex_req, wd_err} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags: got %b exp 000", {mv_start, ex_req, wd_err}); end
        tests_run++; if ({addr, rw_n, dout} !== {16'h0000, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL reset_bus: got %h %b %h exp 0000 1 00", addr, rw_n, dout); end
    endtask

    // Reset vector area holds PSHS #$06; PC wraps from FFFF to 0000.
    task automatic test_first_fetch();
        mv_len = 8'd2;
        reset_b = 1'b1;
        #1;
        tests_run++; if (addr !== 16'hFFFE || mv_start !== 1'b0) begin tests_failed++; $display("FAIL t1_fetch_op: got addr %h start %b exp fffe 0", addr, mv_start); end
        step();
        tests_run++; if ({ir, pc, addr, din, mv_start} !== {8'h34, 16'hFFFF, 16'hFFFF, 8'h06, 1'b1}) begin tests_failed++; $display("FAIL t1_postbyte: got ir %h pc %h addr %h din %h start %b exp 34 ffff ffff 06 1", ir, pc, addr, din, mv_start); end
        step();
        tests_run++; if ({pb, pc, mv_start} !== {8'h06, 16'h0000, 1'b0}) begin tests_failed++; $display("FAIL t1_arm_regs: got pb %h pc %h start %b exp 06 0000 0", pb, pc, mv_start); end
        tests_run++; if ({addr, rw_n, dout} !== {16'h01F2, 1'b0, 8'hA2}) begin tests_failed++; $display("FAIL t1_arm_bus: got %h %b %h exp 01f2 0 a2", addr, rw_n, dout); end
        step();
        tests_run++; if (addr !== 16'h01F1) begin tests_failed++; $display("FAIL t1_wait_mv_bus: got %h exp 01f1", addr); end
        step();
        tests_run++; if ({mv_bus_oe, addr, rw_n, dout} !== {1'b0, 16'h0000, 1'b1, 8'h00}) begin tests_failed++; $display("FAIL t1_idle: got oe %b %h %b %h exp 0 0000 1 00", mv_bus_oe, addr, rw_n, dout); end
        step();
    endtask

    // PSHS with empty register list: MV_ARM falls straight back to fetch.
    task automatic test_pb_zero();
        mv_len = 8'd0;
        step();
        tests_run++; if (addr !== 16'h0001 || mv_start !== 1'b1) begin tests_failed++; $display("FAIL t2_pb_fetch: got addr %h start %b exp 0001 1", addr, mv_start); end
        step();
        tests_run++; if ({pb, addr, rw_n, mv_start} !== {8'h00, 16'h0002, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL t2_arm: got pb %h addr %h rw %b start %b exp 00 0002 1 0", pb, addr, rw_n, mv_start); end
        step();
        tests_run++; if (addr !== 16'h0002 || pc !== 16'h0002 || ir !== 8'h34) begin tests_failed++; $display("FAIL t2_refetch: got addr %h pc %h ir %h exp 0002 0002 34", addr, pc, ir); end
    endtask

    // PSHS #$FF with 12 mover cycles, then TFR to check fetch resume timing.
    task automatic test_mover_hold();
        int n;
        mv_len = 8'd12;
        step();
        tests_run++; if (addr !== 16'h0003 || mv_start !== 1'b1) begin tests_failed++; $display("FAIL t3_pb: got addr %h start %b exp 0003 1", addr, mv_start); end
        step();
        tests_run++; if ({mv_bus_oe, addr, rw_n} !== {1'b1, 16'h01FC, 1'b0}) begin tests_failed++; $display("FAIL t3_handover: got oe %b addr %h rw %b exp 1 01fc 0", mv_bus_oe, addr, rw_n); end
        n = 0;
        while (mv_bus_oe && n < 40) begin
            step();
            n++;
        end
        mv_len = 8'd0;
        tests_run++; if (n !== 12) begin tests_failed++; $display("FAIL t3_oe_len: got %0d cycles exp 12", n); end
        tests_run++; if ({addr, rw_n, ir, mv_start} !== {16'h0004, 1'b1, 8'h34, 1'b0}) begin tests_failed++; $display("FAIL t3_drop_cycle: got addr %h rw %b ir %h start %b exp 0004 1 34 0", addr, rw_n, ir, mv_start); end
        step();
        tests_run++; if (ir !== 8'h34 || addr !== 16'h0004) begin tests_failed++; $display("FAIL t3_resume: got ir %h addr %h exp 34 0004", ir, addr); end
        step();
        tests_run++; if ({ir, mv_start, addr} !== {8'h1F, 1'b1, 16'h0005}) begin tests_failed++; $display("FAIL t3_tfr_pb: got ir %h start %b addr %h exp 1f 1 0005", ir, mv_start, addr); end
        step();
        tests_run++; if ({pb, pc, addr, mv_bus_oe} !== {8'h01, 16'h0006, 16'h0006, 1'b0}) begin tests_failed++; $display("FAIL t3_tfr_done: got pb %h pc %h addr %h oe %b exp 01 0006 0006 0", pb, pc, addr, mv_bus_oe); end
    endtask

    // LDA immediate: execute handshake with bus use and ack on the third cycle.
    task automatic test_exec();
        tests_run++; if (ex_req !== 1'b0) begin tests_failed++; $display("FAIL t4_req_early: got %b exp 0", ex_req); end
        step();
        tests_run++; if ({ex_req, ir, pc, addr} !== {1'b1, 8'h86, 16'h0007, 16'h0007}) begin tests_failed++; $display("FAIL t4_req: got req %b ir %h pc %h addr %h exp 1 86 0007 0007", ex_req, ir, pc, addr); end
        ex_bus_oe = 1'b1; ex_addr = 16'h3000; ex_rw_n = 1'b0; ex_dout = 8'h5A;
        #1;
        tests_run++; if ({addr, rw_n, dout} !== {16'h3000, 1'b0, 8'h5A}) begin tests_failed++; $display("FAIL t4_ex_bus: got %h %b %h exp 3000 0 5a", addr, rw_n, dout); end
        step();
        ex_bus_oe = 1'b0;
        #1;
        tests_run++; if ({addr, rw_n, dout, ex_req} !== {16'h0007, 1'b1, 8'h00, 1'b1}) begin tests_failed++; $display("FAIL t4_idle: got %h %b %h req %b exp 0007 1 00 1", addr, rw_n, dout, ex_req); end
        step();
        ex_ack = 1'b1;
        step();
        ex_ack = 1'b0;
        tests_run++; if ({ex_req, addr, ir} !== {1'b0, 16'h0007, 8'h86}) begin tests_failed++; $display("FAIL t4_ack: got req %b addr %h ir %h exp 0 0007 86", ex_req, addr, ir); end
    endtask

    // ex_ack arrives in the very cycle the watchdog would expire.
    task automatic test_wd_tie();
        step();
        repeat (31) @(posedge clk);
        #2;
        ex_ack = 1'b1;
        #1;
        tests_run++; if (wd_err !== 1'b0 || ex_req !== 1'b1) begin tests_failed++; $display("FAIL tie_pre: got wd %b req %b exp 0 1", wd_err, ex_req); end
        step();
        ex_ack = 1'b0;
        tests_run++; if ({wd_err, ex_req, addr} !== {1'b0, 1'b0, 16'h0008}) begin tests_failed++; $display("FAIL tie_post: got wd %b req %b addr %h exp 0 0 0008", wd_err, ex_req, addr); end
    endtask

    // ex_ack never arrives: watchdog fires after WAIT_MAX cycles and sticks.
    task automatic test_watchdog();
        step();
        repeat (31) @(posedge clk);
        #2;
        tests_run++; if (wd_err !== 1'b0 || ex_req !== 1'b1) begin tests_failed++; $display("FAIL t5_before: got wd %b req %b exp 0 1", wd_err, ex_req); end
        step();
        tests_run++; if ({wd_err, ex_req, addr} !== {1'b1, 1'b0, 16'h0009}) begin tests_failed++; $display("FAIL t5_expire: got wd %b req %b addr %h exp 1 0 0009", wd_err, ex_req, addr); end
        step();
        tests_run++; if ({mv_start, addr, wd_err} !== {1'b1, 16'h000A, 1'b1}) begin tests_failed++; $display("FAIL t5_sticky: got start %b addr %h wd %b exp 1 000a 1", mv_start, addr, wd_err); end
        step();
        step();
        tests_run++; if (addr !== 16'h000B || wd_err !== 1'b1) begin tests_failed++; $display("FAIL t5_sticky2: got addr %h wd %b exp 000b 1", addr, wd_err); end
    endtask

    // halt holds fetch; reset during halt restores reset state asynchronously.
    task automatic test_halt_reset();
        halt = 1'b1;
        repeat (3) step();
        tests_run++; if ({addr, pc, ir, ex_req} !== {16'h000B, 16'h000B, 8'h34, 1'b0}) begin tests_failed++; $display("FAIL t6_halt: got addr %h pc %h ir %h req %b exp 000b 000b 34 0", addr, pc, ir, ex_req); end
        reset_b = 1'b0;
        #1;
        tests_run++; if ({pc, ir, wd_err, addr, rw_n} !== {16'hFFFE, 8'h12, 1'b0, 16'h0000, 1'b1}) begin tests_failed++; $display("FAIL t6_halt_rst: got pc %h ir %h wd %b addr %h rw %b exp fffe 12 0 0000 1", pc, ir, wd_err, addr, rw_n); end
        step();
        reset_b = 1'b1;
        step();
        tests_run++; if ({pc, ir, addr} !== {16'hFFFE, 8'h12, 16'hFFFE}) begin tests_failed++; $display("FAIL t6_halt_hold: got pc %h ir %h addr %h exp fffe 12 fffe", pc, ir, addr); end
        halt = 1'b0;
    endtask

    // Reset asserted while the mover owns the bus.
    task automatic test_reset_in_mv();
        mv_len = 8'd20;
        step();
        step();
        step();
        step();
        tests_run++; if (mv_bus_oe !== 1'b1 || addr !== 16'h0202) begin tests_failed++; $display("FAIL t6_mv_run: got oe %b addr %h exp 1 0202", mv_bus_oe, addr); end
        reset_b = 1'b0;
        #1;
        tests_run++; if ({addr, rw_n, dout, pc, pb, ir} !== {16'h0000, 1'b1, 8'h00, 16'hFFFE, 8'h00, 8'h12}) begin tests_failed++; $display("FAIL t6_mv_rst_bus: got %h %b %h pc %h pb %h ir %h exp 0000 1 00 fffe 00 12", addr, rw_n, dout, pc, pb, ir); end
        tests_run++; if ({mv_start, ex_req, wd_err} !== 3'b000) begin tests_failed++; $display("FAIL t6_mv_rst_flags: got %b exp 000", {mv_start, ex_req, wd_err}); end
        step();
        reset_b = 1'b1;
        #1;
        tests_run++; if (addr !== 16'hFFFE) begin tests_failed++; $display("FAIL t6_release: got %h exp fffe", addr); end
    endtask

    // PULS with PC: the mover reloads PC, next fetch comes from the new PC.
    task automatic test_puls_pc();
        mv_len = 8'd3;
        mv_pc_mode = 1'b1;
        step();
        tests_run++; if (ir !== 8'h35 || mv_start !== 1'b1) begin tests_failed++; $display("FAIL puls_pb: got ir %h start %b exp 35 1", ir, mv_start); end
        step();
        step();
        step();
        step();
        tests_run++; if (pc !== 16'h1234 || addr !== 16'h1234 || mv_bus_oe !== 1'b0) begin tests_failed++; $display("FAIL puls_pc: got pc %h addr %h oe %b exp 1234 1234 0", pc, addr, mv_bus_oe); end
        mv_pc_mode = 1'b0;
        mv_len = 8'd0;
        step();
        tests_run++; if (addr !== 16'h1234 || ir !== 8'h35) begin tests_failed++; $display("FAIL puls_fetch: got addr %h ir %h exp 1234 35", addr, ir); end
        step();
        tests_run++; if ({ir, mv_start, pc} !== {8'h1E, 1'b1, 16'h1235}) begin tests_failed++; $display("FAIL puls_next: got ir %h start %b pc %h exp 1e 1 1235", ir, mv_start, pc); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h12;
        mem[16'hFFFE] = 8'h34; mem[16'hFFFF] = 8'h06;
        mem[16'h0000] = 8'h34; mem[16'h0001] = 8'h00;
        mem[16'h0002] = 8'h34; mem[16'h0003] = 8'hFF;
        mem[16'h0004] = 8'h1F; mem[16'h0005] = 8'h01;
        mem[16'h0006] = 8'h86;
        mem[16'h0007] = 8'h4F;
        mem[16'h0008] = 8'h4F;
        mem[16'h0009] = 8'h34; mem[16'h000A] = 8'h00;
        mem[16'h000B] = 8'h12;
        mem[16'h1234] = 8'h1E;

        test_reset();
        test_first_fetch();
        test_pb_zero();
        test_mover_hold();
        test_exec();
        test_wd_tie();
        test_watchdog();
        test_halt_reset();
        test_reset_in_mv();
        mem[16'hFFFE] = 8'h35; mem[16'hFFFF] = 8'h80;
        test_puls_pc();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got %0d tests run exp completion", tests_run);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
